// File: rtl/vec_lane_seq.sv
// Multi-lane vector integer ALU sequencer: NB_LANES elements per cycle at SEW, tail-undisturbed.
// Optional masking (vm/v0 ports) is compiled in when VEC_SEQ_MASK_EN is defined.
module vec_lane_seq #(
   parameter int unsigned VLEN     = 128,
   parameter int unsigned NB_LANES = 4,
   parameter int unsigned ELEN     = 64
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       start_i,
   input  logic [5:0]                 opcode_i,
   input  logic [2:0]                 op_type_i,
   input  logic [2:0]                 vsew_i,
   input  logic [$clog2(VLEN/8):0]    vl_i,
   input  logic [VLEN-1:0]            vs1_i,
   input  logic [VLEN-1:0]            vs2_i,
   input  logic [VLEN-1:0]            vd_old_i,
   input  logic [ELEN-1:0]            scalar_i,
`ifdef VEC_SEQ_MASK_EN
   input  logic                       vm_i,
   input  logic [VLEN-1:0]            v0_i,
`endif
   output logic                       busy_o,
   output logic                       done_o,
   output logic                       illegal_o,
   output logic [VLEN-1:0]            vd_o
);

   localparam int unsigned IdxW = $clog2(VLEN/8) + 1;
   localparam int unsigned BitW = $clog2(VLEN);
   localparam int unsigned ElW  = $clog2(ELEN);

   localparam logic [5:0] OpAdd  = 6'b000000;
   localparam logic [5:0] OpSub  = 6'b000010;
   localparam logic [5:0] OpRsub = 6'b000011;
   localparam logic [5:0] OpMinu = 6'b000100;
   localparam logic [5:0] OpMin  = 6'b000101;
   localparam logic [5:0] OpMaxu = 6'b000110;
   localparam logic [5:0] OpMax  = 6'b000111;
   localparam logic [5:0] OpAnd  = 6'b001001;
   localparam logic [5:0] OpOr   = 6'b001010;
   localparam logic [5:0] OpXor  = 6'b001011;

   localparam logic [2:0] TypeVV = 3'b001;
   localparam logic [2:0] TypeVX = 3'b010;
   localparam logic [2:0] TypeVI = 3'b100;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e              state_q, state_d;
   logic [5:0]          opcode_q, opcode_d;
   logic                vv_q, vv_d;
   logic [1:0]          vsew_q, vsew_d;
   logic [VLEN-1:0]     vs1_q, vs1_d;
   logic [VLEN-1:0]     vs2_q, vs2_d;
   logic [ELEN-1:0]     scalar_q, scalar_d;
   logic [IdxW-1:0]     nelem_q, nelem_d;
   logic [IdxW-1:0]     idx_q, idx_d;
   logic [VLEN-1:0]     vd_q, vd_d;
   logic                illegal_q, illegal_d;
`ifdef VEC_SEQ_MASK_EN
   logic                vm_q, vm_d;
   logic [VLEN-1:0]     v0_q, v0_d;
`endif

   // Operands are zero- or sign-extended from SEW so compares are exact; upper bits are discarded.
   function automatic logic [ELEN-1:0] alu(input logic [5:0] op, input logic [1:0] sew,
                                           input logic [ELEN-1:0] a, input logic [ELEN-1:0] b);
      int unsigned     w;
      logic [ELEN-1:0] m, au, bu, a_sx, b_sx, res;
      w    = 32'd8 << sew;
      m    = {ELEN{1'b1}} >> (ELEN - w);
      au   = a & m;
      bu   = b & m;
      a_sx = au | (a[ElW'(w - 1)] ? ~m : '0);
      b_sx = bu | (b[ElW'(w - 1)] ? ~m : '0);
      case (op)
         OpAdd:   res = au + bu;
         OpSub:   res = au - bu;
         OpRsub:  res = bu - au;
         OpMinu:  res = (au < bu) ? au : bu;
         OpMin:   res = ($signed(a_sx) < $signed(b_sx)) ? au : bu;
         OpMaxu:  res = (au > bu) ? au : bu;
         OpMax:   res = ($signed(a_sx) > $signed(b_sx)) ? au : bu;
         OpAnd:   res = au & bu;
         OpOr:    res = au | bu;
         OpXor:   res = au ^ bu;
         default: res = '0;
      endcase
      return res;
   endfunction

   always_comb begin
      int unsigned     e;
      int unsigned     cap;
      logic [BitW-1:0] eb, sh;
      logic [ELEN-1:0] a, b, r;
      logic            lane_en, legal;
      state_d   = state_q;
      opcode_d  = opcode_q;
      vv_d      = vv_q;
      vsew_d    = vsew_q;
      vs1_d     = vs1_q;
      vs2_d     = vs2_q;
      scalar_d  = scalar_q;
      nelem_d   = nelem_q;
      idx_d     = idx_q;
      vd_d      = vd_q;
      illegal_d = illegal_q;
`ifdef VEC_SEQ_MASK_EN
      vm_d      = vm_q;
      v0_d      = v0_q;
`endif
      e       = 0;
      cap     = 0;
      eb      = '0;
      sh      = '0;
      a       = '0;
      b       = '0;
      r       = '0;
      lane_en = 1'b0;
      legal   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               legal = !vsew_i[2]
                     && (op_type_i inside {TypeVV, TypeVX, TypeVI})
                     && (opcode_i inside {OpAdd, OpSub, OpRsub, OpMinu, OpMin, OpMaxu, OpMax,
                                          OpAnd, OpOr, OpXor})
                     && !(opcode_i == OpRsub && op_type_i == TypeVV);
               cap       = VLEN >> (32'(vsew_i[1:0]) + 32'd3);
               opcode_d  = opcode_i;
               vv_d      = (op_type_i == TypeVV);
               vsew_d    = vsew_i[1:0];
               vs1_d     = vs1_i;
               vs2_d     = vs2_i;
               scalar_d  = scalar_i;
               // Rejected ops run with zero elements so they share the one-idle-RUN-cycle timing.
               nelem_d   = !legal ? '0 : (32'(vl_i) < cap) ? vl_i : IdxW'(cap);
               illegal_d = !legal;
               idx_d     = '0;
               vd_d      = vd_old_i;
`ifdef VEC_SEQ_MASK_EN
               vm_d      = vm_i;
               v0_d      = v0_i;
`endif
               state_d   = StRun;
            end
         end
         StRun: begin
            if (idx_q >= nelem_q) begin
               state_d = StDone;
            end else begin
               for (int unsigned k = 0; k < NB_LANES; k++) begin
                  e       = 32'(idx_q) + k;
                  eb      = BitW'(e);
                  sh      = BitW'(e << (32'(vsew_q) + 32'd3));
                  a       = ELEN'(vs2_q >> sh);
                  b       = vv_q ? ELEN'(vs1_q >> sh) : scalar_q;
                  r       = alu(opcode_q, vsew_q, a, b);
                  lane_en = (e < 32'(nelem_q));
`ifdef VEC_SEQ_MASK_EN
                  lane_en = lane_en && (vm_q || v0_q[eb]);
`endif
                  if (lane_en) begin
                     unique case (vsew_q)
                        2'd0: vd_d[sh +: 8]  = r[7:0];
                        2'd1: vd_d[sh +: 16] = r[15:0];
                        2'd2: vd_d[sh +: 32] = r[31:0];
                        2'd3: vd_d[sh +: 64] = r[63:0];
                        default: ;
                     endcase
                  end
               end
               idx_d = idx_q + IdxW'(NB_LANES);
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         opcode_q  <= '0;
         vv_q      <= 1'b0;
         vsew_q    <= '0;
         vs1_q     <= '0;
         vs2_q     <= '0;
         scalar_q  <= '0;
         nelem_q   <= '0;
         idx_q     <= '0;
         vd_q      <= '0;
         illegal_q <= 1'b0;
`ifdef VEC_SEQ_MASK_EN
         vm_q      <= 1'b1;
         v0_q      <= '0;
`endif
      end else begin
         state_q   <= state_d;
         opcode_q  <= opcode_d;
         vv_q      <= vv_d;
         vsew_q    <= vsew_d;
         vs1_q     <= vs1_d;
         vs2_q     <= vs2_d;
         scalar_q  <= scalar_d;
         nelem_q   <= nelem_d;
         idx_q     <= idx_d;
         vd_q      <= vd_d;
         illegal_q <= illegal_d;
`ifdef VEC_SEQ_MASK_EN
         vm_q      <= vm_d;
         v0_q      <= v0_d;
`endif
      end
   end

   assign busy_o    = (state_q != StIdle);
   assign done_o    = (state_q == StDone);
   assign illegal_o = done_o & illegal_q;
   assign vd_o      = vd_q;

endmodule

// File: tb/tb_vec_lane_seq.sv
// Directed bench for vec_lane_seq (VLEN=128, NB_LANES=4) with hand-computed results.
// Masked-write vectors are included when VEC_SEQ_MASK_EN is defined.
module tb_vec_lane_seq;

   localparam int unsigned VLEN = 128;
   localparam int unsigned NB   = 4;
   localparam int unsigned ELEN = 64;
   localparam int unsigned VLW  = $clog2(VLEN/8) + 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [5:0]       opcode = '0;
   logic [2:0]       op_type = 3'b001;
   logic [2:0]       vsew = '0;
   logic [VLW-1:0]   vl = '0;
   logic [VLEN-1:0]  vs1 = '0, vs2 = '0, vd_old = '0;
   logic [ELEN-1:0]  scalar = '0;
   logic             busy, done, illegal;
   logic [VLEN-1:0]  vd;
`ifdef VEC_SEQ_MASK_EN
   logic             vm = 1'b1;
   logic [VLEN-1:0]  v0 = '0;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   vec_lane_seq #(.VLEN(VLEN), .NB_LANES(NB), .ELEN(ELEN)) dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .start_i   (start),
      .opcode_i  (opcode),
      .op_type_i (op_type),
      .vsew_i    (vsew),
      .vl_i      (vl),
      .vs1_i     (vs1),
      .vs2_i     (vs2),
      .vd_old_i  (vd_old),
      .scalar_i  (scalar),
`ifdef VEC_SEQ_MASK_EN
      .vm_i      (vm),
      .v0_i      (v0),
`endif
      .busy_o    (busy),
      .done_o    (done),
      .illegal_o (illegal),
      .vd_o      (vd)
   );

   task automatic check_eq(input string tag, input logic [VLEN-1:0] got,
                           input logic [VLEN-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Edge 0 samples start; done is expected after edge exp_edge. inject_at>0 pulses a stray start.
   task automatic run_op(input string tag, input logic [5:0] op, input logic [2:0] ty,
                         input logic [2:0] sew, input logic [VLW-1:0] len,
                         input logic [VLEN-1:0] a1, input logic [VLEN-1:0] a2,
                         input logic [VLEN-1:0] old, input logic [ELEN-1:0] sc,
                         input int exp_edge, input logic exp_ill,
                         input logic [VLEN-1:0] exp_vd, input int inject_at);
      int              done_edge;
      logic            ill_s;
      logic [VLEN-1:0] vd_s;
      done_edge = -1;
      ill_s     = 1'b0;
      vd_s      = '0;
      @(negedge clk);
      opcode = op; op_type = ty; vsew = sew; vl = len;
      vs1 = a1; vs2 = a2; vd_old = old; scalar = sc; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      // Scramble inputs so only latched values can produce the expected result.
      opcode = 6'b111111; op_type = 3'b000; vsew = 3'd7; vl = ~len;
      vs1 = ~a1; vs2 = ~a2; vd_old = ~old; scalar = ~sc;
      check_eq({tag, " busy_after_start"}, VLEN'(busy), VLEN'(1'b1));
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         start = (i == inject_at);
         if (done) begin
            done_edge = i;
            ill_s     = illegal;
            vd_s      = vd;
            break;
         end
      end
      start = 1'b0;
      check_eq({tag, " done_edge"}, VLEN'(done_edge), VLEN'(exp_edge));
      if (done_edge > 0) begin
         check_eq({tag, " illegal"}, VLEN'(ill_s), VLEN'(exp_ill));
         check_eq({tag, " vd"}, vd_s, exp_vd);
         check_eq({tag, " busy_with_done"}, VLEN'(busy), VLEN'(1'b1));
         @(posedge clk); #1;
         check_eq({tag, " done_pulse"}, VLEN'(done), VLEN'(1'b0));
         check_eq({tag, " busy_fall"}, VLEN'(busy), VLEN'(1'b0));
         check_eq({tag, " vd_hold"}, vd, exp_vd);
      end
   endtask

   initial begin
      logic seen_done;
      #2;
      check_eq("rst busy", VLEN'(busy), VLEN'(1'b0));
      check_eq("rst done", VLEN'(done), VLEN'(1'b0));
      check_eq("rst illegal", VLEN'(illegal), VLEN'(1'b0));
      check_eq("rst vd", vd, '0);
      @(negedge clk); rst_n = 1'b1;

      run_op("vadd8", 6'b000000, 3'b001, 3'd0, 5'd16, {16{8'h01}}, {16{8'hFF}},
             128'h0123456789ABCDEF_FEDCBA9876543210, 64'd0, 5, 1'b0, '0, 0);
      run_op("vsub32_vx", 6'b000010, 3'b010, 3'd2, 5'd3, '1,
             128'h00000009_00000007_00000003_0000000A,
             128'hDEADBEEF_11111111_22222222_33333333, 64'd5, 2, 1'b0,
             128'hDEADBEEF_00000002_FFFFFFFE_00000005, 0);
      run_op("vmin64", 6'b000101, 3'b001, 3'd3, 5'd16,
             {64'hFFFF_FFFF_FFFF_FFF8, 64'd2}, {64'd4, 64'hFFFF_FFFF_FFFF_FFFF}, '0, 64'd0,
             2, 1'b0, {64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF}, 0);
      run_op("vminu64", 6'b000100, 3'b001, 3'd3, 5'd16,
             {64'hFFFF_FFFF_FFFF_FFF8, 64'd2}, {64'd4, 64'hFFFF_FFFF_FFFF_FFFF}, '0, 64'd0,
             2, 1'b0, {64'd4, 64'd2}, 0);
      run_op("sew4", 6'b000000, 3'b001, 3'd4, 5'd16, '1, '1,
             128'h0123456789ABCDEF_FEDCBA9876543210, 64'd0, 1, 1'b1,
             128'h0123456789ABCDEF_FEDCBA9876543210, 0);
      run_op("vl0", 6'b000000, 3'b001, 3'd0, 5'd0, '1, '1,
             128'hCAFEBABE_0BADF00D_12345678_9ABCDEF0, 64'd0, 1, 1'b0,
             128'hCAFEBABE_0BADF00D_12345678_9ABCDEF0, 0);
      run_op("vrsub_vv", 6'b000011, 3'b001, 3'd0, 5'd16, '1, '1, {16{8'h5A}}, 64'd0,
             1, 1'b1, {16{8'h5A}}, 0);
      run_op("bad_optype", 6'b000000, 3'b011, 3'd0, 5'd16, '1, '1, {16{8'h3C}}, 64'd0,
             1, 1'b1, {16{8'h3C}}, 0);
      run_op("bad_opcode", 6'b001000, 3'b001, 3'd0, 5'd16, '1, '1, {16{8'hC3}}, 64'd0,
             1, 1'b1, {16{8'hC3}}, 0);
      run_op("vrsub16_vi", 6'b000011, 3'b100, 3'd1, 5'd5, '0, {8{16'h0003}}, {8{16'hAAAA}},
             64'hFFFF_FFFF_FFFF_FFF0, 3, 1'b0,
             128'hAAAA_AAAA_AAAA_FFED_FFED_FFED_FFED_FFED, 0);
      run_op("vmax8", 6'b000111, 3'b001, 3'd0, 5'd4, {96'd0, 32'hFF028001},
             {96'd0, 32'hFE017F80}, '0, 64'd0, 2, 1'b0, {96'd0, 32'hFF027F01}, 0);
      run_op("vmaxu8", 6'b000110, 3'b001, 3'd0, 5'd4, {96'd0, 32'hFF028001},
             {96'd0, 32'hFE017F80}, '0, 64'd0, 2, 1'b0, {96'd0, 32'hFF028080}, 0);
      run_op("vxor8_vx", 6'b001011, 3'b010, 3'd0, 5'd16, '0, {16{8'hA5}}, '0, 64'h0F,
             5, 1'b0, {16{8'hAA}}, 0);
      run_op("vand32", 6'b001001, 3'b001, 3'd2, 5'd4,
             128'h0FF00FF0_0000FFFF_F00FF00F_FFFFFFFF,
             128'hF0F0F0F0_12345678_FFFFFFFF_00000000, '1, 64'd0, 2, 1'b0,
             128'h00F000F0_00005678_F00FF00F_00000000, 0);
      run_op("vor64_vx", 6'b001010, 3'b010, 3'd3, 5'd1, '0,
             {64'd1, 64'h8000_0000_0000_0000}, {64'hCAFEBABE_CAFEBABE, 64'd0}, 64'hFF, 2,
             1'b0, {64'hCAFEBABE_CAFEBABE, 64'h8000_0000_0000_00FF}, 0);
      run_op("vadd16_clamp", 6'b000000, 3'b001, 3'd1, 5'd16, {8{16'h8001}}, {8{16'h8001}},
             '1, 64'd0, 3, 1'b0, {8{16'h0002}}, 0);

      // Reset dropped just after edge 2 of a 4-group operation.
      @(negedge clk);
      opcode = 6'b000000; op_type = 3'b001; vsew = 3'd0; vl = 5'd16;
      vs1 = {16{8'h01}}; vs2 = {16{8'h02}}; vd_old = {16{8'h77}}; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk);
      @(posedge clk); #1 rst_n = 1'b0;
      #1;
      check_eq("midrst vd", vd, '0);
      check_eq("midrst busy", VLEN'(busy), VLEN'(1'b0));
      seen_done = done;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         seen_done = seen_done | done;
      end
      check_eq("midrst no_done", VLEN'(seen_done), VLEN'(1'b0));
      @(negedge clk) rst_n = 1'b1;
      run_op("post_rst_inject", 6'b000000, 3'b001, 3'd0, 5'd16, {16{8'h01}}, {16{8'h02}},
             {16{8'h77}}, 64'd0, 5, 1'b0, {16{8'h03}}, 1);
      seen_done = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         seen_done = seen_done | done;
      end
      check_eq("inject no_queue", VLEN'(seen_done), VLEN'(1'b0));

`ifdef VEC_SEQ_MASK_EN
      vm = 1'b0; v0 = 128'h00FF;
      run_op("mask_vadd8", 6'b000000, 3'b001, 3'd0, 5'd16, {16{8'h01}}, {16{8'h02}},
             {16{8'h77}}, 64'd0, 5, 1'b0, {{8{8'h77}}, {8{8'h03}}}, 0);
      vm = 1'b1;
      run_op("unmask_vadd8", 6'b000000, 3'b001, 3'd0, 5'd16, {16{8'h01}}, {16{8'h02}},
             {16{8'h77}}, 64'd0, 5, 1'b0, {16{8'h03}}, 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
